// File: rtl/mmio_device_select.sv
// Purpose: address decoder / handshake bridge between the core data port and up to 8 MMIO devices.
// Latency: Ack 1 cycle after Req for misses and fault-register accesses; 1+k cycles for a device that is ready after k cycles.
// Backpressure: core holds Req_i until Ack_o; the device stalls via Dev_Ready_i, bounded by a TIMEOUT-cycle watchdog.
//
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   Req_i, We_i, Address_i,
//   Write_Data_i                - core request; sampled only while idle
//   Data_Out_Read, Ack_o, Err_o - registered response; Ack_o is a one-cycle pulse, Err_o valid with it
//   Dev_Sel_o, Dev_We_o,
//   Dev_Re_o, Dev_Write_Data_o  - device-side strobes, held for the whole access
//   Dev_Read_Data_i,
//   Dev_Ready_i                 - per-device read data and completion
module mmio_device_select #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_DEV    = 4,
  parameter logic [NUM_DEV*ADDR_WIDTH-1:0] DEV_BASE =
    {32'h7FFF0000, 32'h04000000, 32'h10010000, 32'h10010020},
  parameter logic [NUM_DEV*ADDR_WIDTH-1:0] DEV_MASK =
    {32'hFFFF0000, 32'hFFC00000, 32'hFFFFF000, 32'hFFFFFFE0},
  parameter logic [ADDR_WIDTH-1:0] FAULT_BASE = 32'h10011000,
  parameter int TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          Req_i,
  input  logic                          We_i,
  input  logic [ADDR_WIDTH-1:0]         Address_i,
  input  logic [DATA_WIDTH-1:0]         Write_Data_i,
  output logic [DATA_WIDTH-1:0]         Data_Out_Read,
  output logic                          Ack_o,
  output logic                          Err_o,
  output logic [NUM_DEV-1:0]            Dev_Sel_o,
  output logic                          Dev_We_o,
  output logic                          Dev_Re_o,
  output logic [DATA_WIDTH-1:0]         Dev_Write_Data_o,
  input  logic [NUM_DEV*DATA_WIDTH-1:0] Dev_Read_Data_i,
  input  logic [NUM_DEV-1:0]            Dev_Ready_i
);

  localparam int IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] FAULT_STAT = FAULT_BASE + ADDR_WIDTH'(4);
  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t                 state;
  logic                   we_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [IDX_W-1:0]       idx_q;
  logic [CNT_W-1:0]       cnt;

  // Captured fault: address plus sticky status bits
  logic [ADDR_WIDTH-1:0]  fault_addr;
  logic                   st_valid;
  logic                   st_unmapped;
  logic                   st_timeout;

  logic                   hit;
  logic [IDX_W-1:0]       hit_idx;
  logic                   sel_ready;
  logic [DATA_WIDTH-1:0]  sel_rdata;

  // Window decode; scanning downward lets the lowest matching index win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      if ((Address_i & DEV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          (DEV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & DEV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Only the latched device's ready and read data are looked at.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_ready = Dev_Ready_i[i];
        sel_rdata = Dev_Read_Data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Device-side strobes depend only on registered state, never directly on inputs.
  always_comb begin
    Dev_Sel_o        = '0;
    Dev_We_o         = 1'b0;
    Dev_Re_o         = 1'b0;
    Dev_Write_Data_o = '0;
    if (state == S_ACCESS) begin
      Dev_Sel_o = NUM_DEV'(1) << idx_q;
      Dev_We_o  = we_q;
      Dev_Re_o  = ~we_q;
      if (we_q) begin
        Dev_Write_Data_o = wdata_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      idx_q         <= '0;
      cnt           <= '0;
      fault_addr    <= '0;
      st_valid      <= 1'b0;
      st_unmapped   <= 1'b0;
      st_timeout    <= 1'b0;
      Data_Out_Read <= '0;
      Ack_o         <= 1'b0;
      Err_o         <= 1'b0;
    end else begin
      Ack_o <= 1'b0;
      Err_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Req_i) begin
            we_q    <= We_i;
            addr_q  <= Address_i;
            wdata_q <= Write_Data_i;
            // Fault registers shadow any device window that overlaps them.
            if (Address_i == FAULT_BASE || Address_i == FAULT_STAT) begin
              state <= S_RESP;
              Ack_o <= 1'b1;
              if (!We_i) begin
                if (Address_i == FAULT_BASE) begin
                  Data_Out_Read <= DATA_WIDTH'(fault_addr);
                end else begin
                  Data_Out_Read <= DATA_WIDTH'({st_timeout, st_unmapped, st_valid});
                  // Read-to-clear, using the pre-clear value loaded above
                  st_valid    <= 1'b0;
                  st_unmapped <= 1'b0;
                  st_timeout  <= 1'b0;
                end
              end else if (Address_i == FAULT_STAT) begin
                st_valid    <= 1'b0;
                st_unmapped <= 1'b0;
                st_timeout  <= 1'b0;
              end
            end else if (hit) begin
              state <= S_ACCESS;
              idx_q <= hit_idx;
              cnt   <= '0;
            end else begin
              state         <= S_RESP;
              Ack_o         <= 1'b1;
              Err_o         <= 1'b1;
              Data_Out_Read <= '0;
              fault_addr    <= Address_i;
              st_valid      <= 1'b1;
              st_unmapped   <= 1'b1;
              st_timeout    <= 1'b0;
            end
          end
        end
        S_ACCESS: begin
          // Ready is tested before the watchdog so a last-cycle ready still succeeds.
          if (sel_ready) begin
            if (!we_q) begin
              Data_Out_Read <= sel_rdata;
            end
            state <= S_RESP;
            Ack_o <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            state         <= S_RESP;
            Ack_o         <= 1'b1;
            Err_o         <= 1'b1;
            Data_Out_Read <= '0;
            fault_addr    <= addr_q;
            st_valid      <= 1'b1;
            st_unmapped   <= 1'b0;
            st_timeout    <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_device_select.sv
module tb_mmio_device_select;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int ND = 4;
  localparam logic [31:0] FB = 32'h10011000;

  logic              clk = 1'b0;
  logic              reset;
  logic              Req_i;
  logic              We_i;
  logic [AW-1:0]     Address_i;
  logic [DW-1:0]     Write_Data_i;
  logic [DW-1:0]     Data_Out_Read;
  logic              Ack_o;
  logic              Err_o;
  logic [ND-1:0]     Dev_Sel_o;
  logic              Dev_We_o;
  logic              Dev_Re_o;
  logic [DW-1:0]     Dev_Write_Data_o;
  logic [ND*DW-1:0]  Dev_Read_Data_i;
  logic [ND-1:0]     Dev_Ready_i;

  mmio_device_select dut (
    .clk              (clk),
    .reset            (reset),
    .Req_i            (Req_i),
    .We_i             (We_i),
    .Address_i        (Address_i),
    .Write_Data_i     (Write_Data_i),
    .Data_Out_Read    (Data_Out_Read),
    .Ack_o            (Ack_o),
    .Err_o            (Err_o),
    .Dev_Sel_o        (Dev_Sel_o),
    .Dev_We_o         (Dev_We_o),
    .Dev_Re_o         (Dev_Re_o),
    .Dev_Write_Data_o (Dev_Write_Data_o),
    .Dev_Read_Data_i  (Dev_Read_Data_i),
    .Dev_Ready_i      (Dev_Ready_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-transaction observations filled in by xact
  int   lat;
  int   acc;
  int   strobe_bad;
  logic err_seen;
  logic [ND-1:0] bg_ready = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One core access. ready_after = 0 means the target never signals ready.
  // lat counts rising edges from the request edge until Ack_o is seen.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input int dev, input int ready_after, input logic hold);
    logic [ND-1:0] exp_sel;
    exp_sel    = ND'(1) << dev;
    @(negedge clk);
    Req_i        = 1'b1;
    We_i         = we;
    Address_i    = addr;
    Write_Data_i = wdata;
    Dev_Ready_i  = bg_ready & ~exp_sel;
    lat        = 0;
    acc        = 0;
    strobe_bad = 0;
    err_seen   = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      lat++;
      if (Ack_o) begin
        err_seen = Err_o;
        break;
      end
      if (Dev_Sel_o != '0) begin
        acc++;
        if (Dev_Sel_o !== exp_sel || Dev_We_o !== we || Dev_Re_o !== ~we ||
            Dev_Write_Data_o !== (we ? wdata : 32'h0))
          strobe_bad++;
        if (ready_after > 0 && acc >= ready_after)
          Dev_Ready_i[dev] = 1'b1;
      end
    end
    if (!hold) Req_i = 1'b0;
    Dev_Ready_i = '0;
    @(posedge clk);
    #1;
    Req_i = 1'b0;
    check("ack_one_cycle", {31'b0, Ack_o}, 32'h0);
    check("idle_after_resp", {28'b0, Dev_Sel_o}, 32'h0);
  endtask

  initial begin
    int ack_cnt;
    reset        = 1'b1;
    Req_i        = 1'b0;
    We_i         = 1'b0;
    Address_i    = '0;
    Write_Data_i = '0;
    Dev_Ready_i  = '0;
    Dev_Read_Data_i = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11111111};
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", Data_Out_Read, 32'h0);
    check("rst_ack_err", {30'b0, Ack_o, Err_o}, 32'h0);
    check("rst_sel", {28'b0, Dev_Sel_o}, 32'h0);
    check("rst_we_re", {30'b0, Dev_We_o, Dev_Re_o}, 32'h0);
    check("rst_wdata", Dev_Write_Data_o, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Read from device 1, ready immediately
    xact(1'b0, 32'h10010004, 32'h0, 1, 1, 1'b0);
    check("rd1_lat", lat, 2);
    check("rd1_acc", acc, 1);
    check("rd1_err", {31'b0, err_seen}, 32'h0);
    check("rd1_data", Data_Out_Read, 32'hDEADBEEF);
    check("rd1_strobes", strobe_bad, 0);

    // Write hits windows 0 and 1; window 0 must win. Ready after 3 cycles.
    xact(1'b1, 32'h1001002C, 32'h41, 0, 3, 1'b0);
    check("wr0_lat", lat, 4);
    check("wr0_acc", acc, 3);
    check("wr0_err", {31'b0, err_seen}, 32'h0);
    check("wr0_strobes", strobe_bad, 0);
    check("wr0_data_held", Data_Out_Read, 32'hDEADBEEF);
    check("wr0_wdata_after", Dev_Write_Data_o, 32'h0);
    check("wr0_we_after", {31'b0, Dev_We_o}, 32'h0);

    // Unmapped read, then fault register readback
    xact(1'b0, 32'h20000000, 32'h0, 0, 0, 1'b0);
    check("miss_lat", lat, 1);
    check("miss_err", {31'b0, err_seen}, 32'h1);
    check("miss_data", Data_Out_Read, 32'h0);
    check("miss_acc", acc, 0);
    xact(1'b0, FB, 32'h0, 0, 0, 1'b0);
    check("fa_lat", lat, 1);
    check("fa_err", {31'b0, err_seen}, 32'h0);
    check("fa_data", Data_Out_Read, 32'h20000000);
    xact(1'b0, FB + 32'h4, 32'h0, 0, 0, 1'b0);
    check("fs_miss", Data_Out_Read, 32'h3);
    xact(1'b0, FB + 32'h4, 32'h0, 0, 0, 1'b0);
    check("fs_cleared", Data_Out_Read, 32'h0);

    // Timeout on device 2 while every other device claims ready
    bg_ready = 4'b1111;
    xact(1'b0, 32'h04000010, 32'h0, 2, 0, 1'b0);
    bg_ready = 4'b0000;
    check("to_lat", lat, 17);
    check("to_acc", acc, 16);
    check("to_err", {31'b0, err_seen}, 32'h1);
    check("to_data", Data_Out_Read, 32'h0);
    check("to_strobes", strobe_bad, 0);
    xact(1'b0, FB, 32'h0, 0, 0, 1'b0);
    check("to_fault_addr", Data_Out_Read, 32'h04000010);
    xact(1'b1, FB, 32'h12345678, 0, 0, 1'b0);
    check("fa_wr_err", {31'b0, err_seen}, 32'h0);
    xact(1'b0, FB, 32'h0, 0, 0, 1'b0);
    check("fa_wr_ignored", Data_Out_Read, 32'h04000010);
    xact(1'b0, FB + 32'h4, 32'h0, 0, 0, 1'b0);
    check("fs_timeout", Data_Out_Read, 32'h5);

    // Write to the status word clears a fresh fault
    xact(1'b0, 32'h30000000, 32'h0, 0, 0, 1'b0);
    check("miss2_err", {31'b0, err_seen}, 32'h1);
    xact(1'b1, FB + 32'h4, 32'h0, 0, 0, 1'b0);
    xact(1'b0, FB + 32'h4, 32'h0, 0, 0, 1'b0);
    check("fs_wr_clear", Data_Out_Read, 32'h0);

    // Device 3 ready on the very last allowed cycle
    xact(1'b0, 32'h7FFF0010, 32'h0, 3, 16, 1'b0);
    check("last_lat", lat, 17);
    check("last_acc", acc, 16);
    check("last_err", {31'b0, err_seen}, 32'h0);
    check("last_data", Data_Out_Read, 32'h33333333);
    xact(1'b0, FB + 32'h4, 32'h0, 0, 0, 1'b0);
    check("last_no_fault", Data_Out_Read, 32'h0);

    // Req held one cycle past Ack must not start a second access
    xact(1'b0, 32'h10010008, 32'h0, 1, 1, 1'b1);
    check("hold_lat", lat, 2);
    @(posedge clk);
    #1;
    check("hold_no_reaccept", {28'b0, Dev_Sel_o}, 32'h0);

    // Reset in the middle of an access
    xact(1'b0, 32'h20000040, 32'h0, 0, 0, 1'b0);
    @(negedge clk);
    Req_i     = 1'b1;
    We_i      = 1'b0;
    Address_i = 32'h04000010;
    @(posedge clk);
    #1;
    check("rst_mid_sel_before", {28'b0, Dev_Sel_o}, 32'h4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_sel", {28'b0, Dev_Sel_o}, 32'h0);
    Req_i   = 1'b0;
    reset   = 1'b0;
    ack_cnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (Ack_o) ack_cnt++;
    end
    check("rst_mid_no_ack", ack_cnt, 0);
    xact(1'b0, FB + 32'h4, 32'h0, 0, 0, 1'b0);
    check("rst_mid_status", Data_Out_Read, 32'h0);
    xact(1'b0, FB, 32'h0, 0, 0, 1'b0);
    check("rst_mid_addr", Data_Out_Read, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
